// File: rtl/regfile_sb.sv
// regfile_sb: register file with integrated write-pending scoreboard.
// ID locks destinations at issue, WB writes and releases them.
//
// Ports:
//   clk             core clock, rising edge
//   rst             asynchronous active-low reset
//   rd_en           per-port read request (gates hazard detection only)
//   rd_addr         packed read addresses, port i at [i*ADDR_W +: ADDR_W]
//   rd_data         packed read data, port i at [i*DATA_W +: DATA_W]
//   issue_valid     ID presents an instruction
//   issue_wr        that instruction writes a register
//   issue_addr      its destination
//   wb_en           WB writes a register
//   wb_addr         WB destination
//   wb_data         WB value
//   flush           squash, clears all locks
//   hold            combinational stall request
//   busy_count      registered count of locked registers
//   err_wb_unlocked sticky flag, WB to an unlocked register
module regfile_sb #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 4,
    parameter int NUM_RD   = 2,
    parameter bit BYPASS   = 1'b1,
    parameter bit ZERO_REG = 1'b0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_RD-1:0]        rd_en,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    input  logic                     issue_valid,
    input  logic                     issue_wr,
    input  logic [ADDR_W-1:0]        issue_addr,
    input  logic                     wb_en,
    input  logic [ADDR_W-1:0]        wb_addr,
    input  logic [DATA_W-1:0]        wb_data,
    input  logic                     flush,
    output logic                     hold,
    output logic [ADDR_W:0]          busy_count,
    output logic                     err_wb_unlocked
);

    localparam int NREG = 1 << ADDR_W;

    logic [DATA_W-1:0] r_regs [NREG];
    logic [NREG-1:0]   r_pend;
    logic [ADDR_W:0]   r_busy;
    logic              r_err;

    logic [NUM_RD-1:0] w_raw;
    logic [NREG-1:0]   w_pend_nxt;
    logic [ADDR_W:0]   w_busy_nxt;
    logic              w_waw;
    logic              w_hold;
    logic              w_accept;
    logic              w_wb_zero;
    logic              w_iss_zero;
    logic              w_wb_wr;
    logic              w_set_err;

    assign w_wb_zero  = ZERO_REG && (wb_addr == '0);
    assign w_iss_zero = ZERO_REG && (issue_addr == '0);

    // Read ports and per-port RAW detection. A same-cycle WB to the
    // read address satisfies the read only when it is forwarded.
    always_comb begin : rd_blk
        logic [ADDR_W-1:0] w_ra;
        logic              w_zero;
        logic              w_byp;
        rd_data = '0;
        w_raw   = '0;
        for (int i = 0; i < NUM_RD; i++) begin
            w_ra   = rd_addr[i*ADDR_W +: ADDR_W];
            w_zero = ZERO_REG && (w_ra == '0);
            w_byp  = BYPASS && wb_en && (wb_addr == w_ra);
            if (w_zero) begin
                rd_data[i*DATA_W +: DATA_W] = '0;
            end else if (w_byp) begin
                rd_data[i*DATA_W +: DATA_W] = wb_data;
            end else begin
                rd_data[i*DATA_W +: DATA_W] = r_regs[w_ra];
            end
            w_raw[i] = rd_en[i] && r_pend[w_ra] && !w_zero && !w_byp;
        end
    end

    // A WB retiring the old writer clears the WAW conflict even
    // without forwarding: the new lock simply replaces the old one.
    assign w_waw = issue_valid && issue_wr && r_pend[issue_addr]
                && !(wb_en && (wb_addr == issue_addr))
                && !w_iss_zero;

    assign w_hold   = (|w_raw) || w_waw;
    assign w_accept = issue_valid && !w_hold && !flush;

    // Set is applied after clear: the issuing instruction is newer
    // than the one retiring, so its lock must survive.
    always_comb begin
        w_pend_nxt = r_pend;
        if (flush) begin
            w_pend_nxt = '0;
        end else begin
            if (wb_en) begin
                w_pend_nxt[wb_addr] = 1'b0;
            end
            if (w_accept && issue_wr && !w_iss_zero) begin
                w_pend_nxt[issue_addr] = 1'b1;
            end
        end
    end

    always_comb begin
        w_busy_nxt = '0;
        for (int a = 0; a < NREG; a++) begin
            w_busy_nxt = w_busy_nxt + {{ADDR_W{1'b0}}, w_pend_nxt[a]};
        end
    end

    // Retiring writes are never squashed, so flush does not gate them.
    assign w_wb_wr   = wb_en && !w_wb_zero;
    assign w_set_err = wb_en && !w_wb_zero && !r_pend[wb_addr] && !flush;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int a = 0; a < NREG; a++) begin
                r_regs[a] <= '0;
            end
        end else if (w_wb_wr) begin
            r_regs[wb_addr] <= wb_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pend <= '0;
            r_busy <= '0;
            r_err  <= 1'b0;
        end else begin
            r_pend <= w_pend_nxt;
            r_busy <= w_busy_nxt;
            if (w_set_err) begin
                r_err <= 1'b1;
            end
        end
    end

    assign hold            = w_hold;
    assign busy_count      = r_busy;
    assign err_wb_unlocked = r_err;

endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: drives two regfile_sb configurations with the same
// stimulus (A: BYPASS=1 ZERO_REG=0, B: BYPASS=0 ZERO_REG=1).
module tb_regfile_sb;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  rd_en;
    logic [7:0]  rd_addr;
    logic        issue_valid;
    logic        issue_wr;
    logic [3:0]  issue_addr;
    logic        wb_en;
    logic [3:0]  wb_addr;
    logic [15:0] wb_data;
    logic        flush;

    logic [31:0] rd_data_a, rd_data_b;
    logic        hold_a, hold_b;
    logic [4:0]  busy_a, busy_b;
    logic        err_a, err_b;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    regfile_sb #(
        .DATA_W(16), .ADDR_W(4), .NUM_RD(2),
        .BYPASS(1'b1), .ZERO_REG(1'b0)
    ) dut_a (
        .clk(clk), .rst(rst),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_a),
        .issue_valid(issue_valid), .issue_wr(issue_wr),
        .issue_addr(issue_addr),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .flush(flush), .hold(hold_a), .busy_count(busy_a),
        .err_wb_unlocked(err_a)
    );

    regfile_sb #(
        .DATA_W(16), .ADDR_W(4), .NUM_RD(2),
        .BYPASS(1'b0), .ZERO_REG(1'b1)
    ) dut_b (
        .clk(clk), .rst(rst),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_b),
        .issue_valid(issue_valid), .issue_wr(issue_wr),
        .issue_addr(issue_addr),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .flush(flush), .hold(hold_b), .busy_count(busy_b),
        .err_wb_unlocked(err_b)
    );

    // Reference model: c=0 mirrors dut_a, c=1 mirrors dut_b.
    logic [15:0] m_regs [2][16];
    bit          m_pend [2][16];
    int          m_busy [2];
    bit          m_err  [2];

    function automatic bit byp(int c);
        return c == 0;
    endfunction

    function automatic bit zr(int c);
        return c == 1;
    endfunction

    function automatic void m_reset();
        for (int c = 0; c < 2; c++) begin
            for (int a = 0; a < 16; a++) begin
                m_regs[c][a] = 16'h0;
                m_pend[c][a] = 1'b0;
            end
            m_busy[c] = 0;
            m_err[c]  = 1'b0;
        end
    endfunction

    function automatic logic [15:0] m_rd(int c, int p);
        logic [3:0] a;
        a = rd_addr[4*p +: 4];
        if (zr(c) && a == 4'd0) return 16'h0;
        if (byp(c) && wb_en && wb_addr == a) return wb_data;
        return m_regs[c][a];
    endfunction

    function automatic bit m_hold(int c);
        bit         h;
        logic [3:0] a;
        h = 1'b0;
        for (int p = 0; p < 2; p++) begin
            a = rd_addr[4*p +: 4];
            if (rd_en[p] && m_pend[c][a]
                && !(zr(c) && a == 4'd0)
                && !(byp(c) && wb_en && wb_addr == a))
                h = 1'b1;
        end
        if (issue_valid && issue_wr && m_pend[c][issue_addr]
            && !(wb_en && wb_addr == issue_addr)
            && !(zr(c) && issue_addr == 4'd0))
            h = 1'b1;
        return h;
    endfunction

    function automatic void m_advance(int c);
        bit h, acc, wz;
        h   = m_hold(c);
        acc = issue_valid && !h && !flush;
        wz  = zr(c) && wb_addr == 4'd0;
        if (wb_en && !wz && !m_pend[c][wb_addr] && !flush)
            m_err[c] = 1'b1;
        if (wb_en && !wz)
            m_regs[c][wb_addr] = wb_data;
        if (flush) begin
            for (int a = 0; a < 16; a++) m_pend[c][a] = 1'b0;
        end else begin
            if (wb_en) m_pend[c][wb_addr] = 1'b0;
            if (acc && issue_wr && !(zr(c) && issue_addr == 4'd0))
                m_pend[c][issue_addr] = 1'b1;
        end
        m_busy[c] = 0;
        for (int a = 0; a < 16; a++) m_busy[c] += int'(m_pend[c][a]);
    endfunction

    task automatic idle();
        rd_en       = 2'b00;
        rd_addr     = 8'h00;
        issue_valid = 1'b0;
        issue_wr    = 1'b0;
        issue_addr  = 4'h0;
        wb_en       = 1'b0;
        wb_addr     = 4'h0;
        wb_data     = 16'h0;
        flush       = 1'b0;
    endtask

    // Advance one clock: model takes pre-edge inputs, DUT sees the edge.
    task automatic tick();
        m_advance(0);
        m_advance(1);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b0;
        m_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic test_reset();
        idle();
        rst = 1'b0;
        m_reset();
        #3;
        n_chk++;
        if ({hold_a, hold_b} !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_hold: got %b%b want 00", hold_a, hold_b);
        end
        n_chk++;
        if ({busy_a, busy_b} !== 10'd0) begin
            n_fail++;
            $display("FAIL reset_busy: got %0d/%0d want 0", busy_a, busy_b);
        end
        n_chk++;
        if ({err_a, err_b} !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_err: got %b%b want 00", err_a, err_b);
        end
        rd_addr = 8'h5A;
        #1;
        n_chk++;
        if ({rd_data_a, rd_data_b} !== 64'h0) begin
            n_fail++;
            $display("FAIL reset_rd: got %h %h want 0", rd_data_a, rd_data_b);
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        idle();
    endtask

    task automatic test_write_read();
        do_reset();
        wb_en = 1'b1; wb_addr = 4'd3; wb_data = 16'h1234;
        tick();
        idle();
        rd_en = 2'b01; rd_addr = 8'h03;
        #1;
        n_chk++;
        if (rd_data_a[15:0] !== 16'h1234 || rd_data_b[15:0] !== 16'h1234) begin
            n_fail++;
            $display("FAIL wr_rd_data: got %h %h want 1234",
                     rd_data_a[15:0], rd_data_b[15:0]);
        end
        n_chk++;
        if ({hold_a, hold_b} !== 2'b00) begin
            n_fail++;
            $display("FAIL wr_rd_hold: got %b%b want 00", hold_a, hold_b);
        end
        n_chk++;
        if ({err_a, err_b} !== 2'b11) begin
            n_fail++;
            $display("FAIL wr_rd_err: got %b%b want 11", err_a, err_b);
        end
    endtask

    task automatic test_raw_release();
        do_reset();
        issue_valid = 1'b1; issue_wr = 1'b1; issue_addr = 4'd5;
        tick();
        idle();
        rd_en = 2'b10; rd_addr = 8'h50;
        #1;
        n_chk++;
        if ({hold_a, hold_b} !== 2'b11) begin
            n_fail++;
            $display("FAIL raw_hold: got %b%b want 11", hold_a, hold_b);
        end
        n_chk++;
        if (busy_a !== 5'd1 || busy_b !== 5'd1) begin
            n_fail++;
            $display("FAIL raw_busy: got %0d/%0d want 1", busy_a, busy_b);
        end
        wb_en = 1'b1; wb_addr = 4'd5; wb_data = 16'hBEEF;
        #1;
        n_chk++;
        if (hold_a !== 1'b0 || rd_data_a[31:16] !== 16'hBEEF) begin
            n_fail++;
            $display("FAIL raw_bypass: got hold=%b data=%h want 0 beef",
                     hold_a, rd_data_a[31:16]);
        end
        n_chk++;
        if (hold_b !== 1'b1) begin
            n_fail++;
            $display("FAIL raw_nobyp_hold: got %b want 1", hold_b);
        end
        tick();
        wb_en = 1'b0;
        #1;
        n_chk++;
        if (hold_b !== 1'b0 || rd_data_b[31:16] !== 16'hBEEF) begin
            n_fail++;
            $display("FAIL raw_nobyp_release: got hold=%b data=%h want 0 beef",
                     hold_b, rd_data_b[31:16]);
        end
        n_chk++;
        if ({busy_a, busy_b} !== 10'd0 || {err_a, err_b} !== 2'b00) begin
            n_fail++;
            $display("FAIL raw_after: got busy %0d/%0d err %b%b want 0 00",
                     busy_a, busy_b, err_a, err_b);
        end
    endtask

    task automatic test_waw();
        do_reset();
        issue_valid = 1'b1; issue_wr = 1'b1; issue_addr = 4'd2;
        tick();
        #1;
        n_chk++;
        if ({hold_a, hold_b} !== 2'b11) begin
            n_fail++;
            $display("FAIL waw_hold: got %b%b want 11", hold_a, hold_b);
        end
        tick();
        n_chk++;
        if (busy_a !== 5'd1 || busy_b !== 5'd1) begin
            n_fail++;
            $display("FAIL waw_busy: got %0d/%0d want 1", busy_a, busy_b);
        end
        wb_en = 1'b1; wb_addr = 4'd2; wb_data = 16'h7777;
        #1;
        n_chk++;
        if ({hold_a, hold_b} !== 2'b00) begin
            n_fail++;
            $display("FAIL waw_wb_hold: got %b%b want 00", hold_a, hold_b);
        end
        tick();
        idle();
        rd_en = 2'b01; rd_addr = 8'h02;
        #1;
        n_chk++;
        if ({hold_a, hold_b} !== 2'b11 || busy_a !== 5'd1 || busy_b !== 5'd1) begin
            n_fail++;
            $display("FAIL waw_relock: got hold %b%b busy %0d/%0d want 11 1",
                     hold_a, hold_b, busy_a, busy_b);
        end
        n_chk++;
        if (rd_data_a[15:0] !== 16'h7777 || rd_data_b[15:0] !== 16'h7777) begin
            n_fail++;
            $display("FAIL waw_data: got %h %h want 7777",
                     rd_data_a[15:0], rd_data_b[15:0]);
        end
    endtask

    task automatic test_flush();
        logic [3:0] locks [3];
        locks = '{4'd1, 4'd4, 4'd7};
        do_reset();
        for (int k = 0; k < 3; k++) begin
            issue_valid = 1'b1; issue_wr = 1'b1; issue_addr = locks[k];
            tick();
            n_chk++;
            if (busy_a !== 5'(k + 1) || busy_b !== 5'(k + 1)) begin
                n_fail++;
                $display("FAIL flush_lock%0d: got %0d/%0d want %0d",
                         k, busy_a, busy_b, k + 1);
            end
        end
        idle();
        flush = 1'b1; wb_en = 1'b1; wb_addr = 4'd4; wb_data = 16'h0042;
        tick();
        idle();
        rd_en = 2'b11; rd_addr = 8'h71;
        #1;
        n_chk++;
        if ({hold_a, hold_b} !== 2'b00 || {busy_a, busy_b} !== 10'd0) begin
            n_fail++;
            $display("FAIL flush_clear: got hold %b%b busy %0d/%0d want 00 0",
                     hold_a, hold_b, busy_a, busy_b);
        end
        n_chk++;
        if ({err_a, err_b} !== 2'b00) begin
            n_fail++;
            $display("FAIL flush_err: got %b%b want 00", err_a, err_b);
        end
        rd_addr = 8'h74;
        #1;
        n_chk++;
        if (rd_data_a[15:0] !== 16'h0042 || rd_data_b[15:0] !== 16'h0042) begin
            n_fail++;
            $display("FAIL flush_wb: got %h %h want 0042",
                     rd_data_a[15:0], rd_data_b[15:0]);
        end
    endtask

    task automatic test_zero_reg();
        do_reset();
        issue_valid = 1'b1; issue_wr = 1'b1; issue_addr = 4'd0;
        tick();
        idle();
        rd_en = 2'b01; rd_addr = 8'h00;
        #1;
        n_chk++;
        if (hold_b !== 1'b0 || busy_b !== 5'd0) begin
            n_fail++;
            $display("FAIL zero_lock: got hold %b busy %0d want 0 0",
                     hold_b, busy_b);
        end
        n_chk++;
        if (hold_a !== 1'b1 || busy_a !== 5'd1) begin
            n_fail++;
            $display("FAIL r0_normal_lock: got hold %b busy %0d want 1 1",
                     hold_a, busy_a);
        end
        wb_en = 1'b1; wb_addr = 4'd0; wb_data = 16'hFFFF;
        #1;
        n_chk++;
        if (rd_data_b[15:0] !== 16'h0 || hold_b !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_wb: got data %h hold %b want 0 0",
                     rd_data_b[15:0], hold_b);
        end
        tick();
        wb_en = 1'b0;
        #1;
        n_chk++;
        if (rd_data_b[15:0] !== 16'h0 || rd_data_a[15:0] !== 16'hFFFF) begin
            n_fail++;
            $display("FAIL zero_after: got %h %h want 0000 ffff",
                     rd_data_b[15:0], rd_data_a[15:0]);
        end
        n_chk++;
        if ({err_a, err_b} !== 2'b00 || {busy_a, busy_b} !== 10'd0) begin
            n_fail++;
            $display("FAIL zero_state: got err %b%b busy %0d/%0d want 00 0",
                     err_a, err_b, busy_a, busy_b);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        wb_en = 1'b1; wb_addr = 4'd9; wb_data = 16'h5555;
        tick();
        idle();
        issue_valid = 1'b1; issue_wr = 1'b1; issue_addr = 4'd6;
        tick();
        idle();
        rd_en = 2'b01; rd_addr = 8'h96;
        #1;
        n_chk++;
        if ({hold_a, hold_b} !== 2'b11 || rd_data_a[31:16] !== 16'h5555) begin
            n_fail++;
            $display("FAIL arst_pre: got hold %b%b data %h want 11 5555",
                     hold_a, hold_b, rd_data_a[31:16]);
        end
        #2;
        rst = 1'b0;
        #1;
        n_chk++;
        if ({hold_a, hold_b} !== 2'b00 || {busy_a, busy_b} !== 10'd0) begin
            n_fail++;
            $display("FAIL arst_lock: got hold %b%b busy %0d/%0d want 00 0",
                     hold_a, hold_b, busy_a, busy_b);
        end
        n_chk++;
        if ({rd_data_a, rd_data_b} !== 64'h0 || {err_a, err_b} !== 2'b00) begin
            n_fail++;
            $display("FAIL arst_data: got %h %h err %b%b want 0",
                     rd_data_a, rd_data_b, err_a, err_b);
        end
        m_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic test_random(int cycles);
        int          q [$];
        logic [31:0] dut_rd;
        logic        dut_h, dut_e;
        logic [4:0]  dut_b;
        do_reset();
        for (int n = 0; n < cycles; n++) begin
            if ($urandom_range(0, 59) == 0) do_reset();
            rd_en       = 2'($urandom);
            rd_addr     = {4'($urandom_range(0, 7)), 4'($urandom_range(0, 7))};
            issue_valid = ($urandom_range(0, 9) < 7);
            issue_wr    = ($urandom_range(0, 9) < 8);
            issue_addr  = 4'($urandom_range(0, 9));
            wb_en       = $urandom_range(0, 1) == 1;
            wb_data     = 16'($urandom);
            flush       = ($urandom_range(0, 19) == 0);
            q.delete();
            for (int a = 0; a < 16; a++) if (m_pend[0][a]) q.push_back(a);
            if (q.size() > 0 && $urandom_range(0, 9) < 8)
                wb_addr = 4'(q[$urandom_range(0, q.size() - 1)]);
            else
                wb_addr = 4'($urandom_range(0, 15));
            #1;
            for (int c = 0; c < 2; c++) begin
                dut_rd = (c == 0) ? rd_data_a : rd_data_b;
                dut_h  = (c == 0) ? hold_a : hold_b;
                dut_b  = (c == 0) ? busy_a : busy_b;
                dut_e  = (c == 0) ? err_a : err_b;
                n_chk++;
                if (dut_h !== m_hold(c)) begin
                    n_fail++;
                    $display("FAIL rnd_hold cfg%0d cyc%0d: got %b want %b",
                             c, n, dut_h, m_hold(c));
                end
                n_chk++;
                if (dut_b !== 5'(m_busy[c])) begin
                    n_fail++;
                    $display("FAIL rnd_busy cfg%0d cyc%0d: got %0d want %0d",
                             c, n, dut_b, m_busy[c]);
                end
                n_chk++;
                if (dut_e !== m_err[c]) begin
                    n_fail++;
                    $display("FAIL rnd_err cfg%0d cyc%0d: got %b want %b",
                             c, n, dut_e, m_err[c]);
                end
                for (int p = 0; p < 2; p++) begin
                    n_chk++;
                    if (dut_rd[16*p +: 16] !== m_rd(c, p)) begin
                        n_fail++;
                        $display("FAIL rnd_rd cfg%0d p%0d cyc%0d: got %h want %h",
                                 c, p, n, dut_rd[16*p +: 16], m_rd(c, p));
                    end
                end
            end
            tick();
        end
        idle();
    endtask

    initial begin
        idle();
        rst = 1'b1;
        test_reset();
        test_write_read();
        test_raw_release();
        test_waw();
        test_flush();
        test_zero_reg();
        test_async_reset();
        test_random(400);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
